// File: rtl/seq_pkg.sv
// seq_pkg: opcodes, instruction field helpers and program-word macros for seq_engine.
// Instruction format is [opcode 3][n AW][d DDW].
package seq_pkg;

    typedef enum logic [2:0] {
        OP_STOP   = 3'd0,
        OP_OUT    = 3'd1,
        OP_JMP    = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4,
        OP_PUSHI  = 3'd5,
        OP_DECJNZ = 3'd6
    } op_e;

    function automatic logic [2:0] f_op(input logic [63:0] w, input int ocw);
        return 3'(w >> (ocw - 3));
    endfunction

    function automatic logic [31:0] f_n(input logic [63:0] w, input int ocw, input int ddw);
        return 32'((w >> ddw) & ((64'd1 << (ocw - ddw - 3)) - 64'd1));
    endfunction

    function automatic logic [31:0] f_d(input logic [63:0] w, input int ddw);
        return 32'(w & ((64'd1 << ddw) - 64'd1));
    endfunction

endpackage

// Word builders for the default 12-bit format (AW=5, DDW=4).
`ifndef SEQ_PKG_MACROS
`define SEQ_PKG_MACROS
`define SEQ_STOP(n, d)   {3'd0, 5'(n), 4'(d)}
`define SEQ_OUT(n, d)    {3'd1, 5'(n), 4'(d)}
`define SEQ_JMP(n, d)    {3'd2, 5'(n), 4'(d)}
`define SEQ_CALL(n, d)   {3'd3, 5'(n), 4'(d)}
`define SEQ_RET(n, d)    {3'd4, 5'(n), 4'(d)}
`define SEQ_PUSHI(n, d)  {3'd5, 5'(n), 4'(d)}
`define SEQ_DECJNZ(n, d) {3'd6, 5'(n), 4'(d)}
`endif

// File: rtl/seq_cmd_fifo.sv
// seq_cmd_fifo: show-ahead synchronous FIFO of program entry addresses.
module seq_cmd_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          do_rd, do_wr;

    // A write into a full FIFO still lands if a read frees a slot on the same edge.
    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (do_rd) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= wr_data;

endmodule

// File: rtl/seq_engine.sv
// seq_engine: microcoded pattern sequencer running ROM programs from queued entry addresses.
// Stack, PC and decode live here; entry addresses come from seq_cmd_fifo.
module seq_engine
    import seq_pkg::*;
#(
    parameter int                  OCW     = 12,
    parameter int                  DDW     = 4,
    parameter int                  PLEN    = 31,
    parameter int                  STD     = 256,
    parameter int                  FDEPTH  = 256,
    parameter logic [PLEN*OCW-1:0] PROGRAM = '0,
    localparam int                 AW      = OCW - DDW - 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    output logic           fifo_full,
    output logic           fifo_empty,
    output logic [DDW-1:0] data_o,
    output logic [AW-1:0]  pc,
    output logic           stop
);

    localparam int SPW = $clog2(STD + 1);
    localparam int SIW = $clog2(STD);

    logic            run, adv, do_load, go_idle, fifo_pop, has_top;
    logic            push, pop, wtop, halt;
    logic [AW-1:0]   cnt, n, ln, nxt, la, top, push_val, lcnt, fifo_data;
    logic [SPW-1:0]  sp;
    logic [AW-1:0]   stk [STD];
    logic [OCW-1:0]  cw, lw;
    logic [2:0]      op, lop;

    function automatic logic [OCW-1:0] fetch(input logic [AW-1:0] a);
        int idx;
        idx = (int'(a) < PLEN) ? PLEN - 1 - int'(a) : 0;
        return (int'(a) < PLEN) ? PROGRAM[idx*OCW +: OCW] : '0;
    endfunction

    function automatic logic valid(input logic [AW-1:0] a);
        return a != '0 && int'(a) < PLEN;
    endfunction

    seq_cmd_fifo #(.W(AW), .DEPTH(FDEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_addr),
        .rd_en   (fifo_pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign stop = !run;

    always_comb begin
        cw       = fetch(pc);
        op       = f_op(64'(cw), OCW);
        n        = AW'(f_n(64'(cw), OCW, DDW));
        has_top  = sp != '0;
        top      = has_top ? stk[SIW'(sp - 1'b1)] : '0;
        adv      = run && cnt == '0;
        nxt      = pc + 1'b1;
        push_val = pc + 1'b1;
        push     = 1'b0;
        pop      = 1'b0;
        wtop     = 1'b0;
        halt     = 1'b0;
        case (op)
            OP_OUT:    ;
            OP_JMP:    nxt = n;
            OP_CALL:   begin push = 1'b1; nxt = n; end
            OP_RET:    if (has_top) begin pop = 1'b1; nxt = top; end
            OP_PUSHI:  begin push = 1'b1; push_val = n; end
            OP_DECJNZ: if (has_top && top != AW'(1)) begin wtop = 1'b1; nxt = n; end
                       else if (has_top) pop = 1'b1;
            default:   halt = 1'b1;
        endcase
        // The address to load is either the successor or, while idle, the FIFO head.
        fifo_pop = !run && !fifo_empty;
        la       = run ? nxt : fifo_data;
        lw       = fetch(la);
        lop      = f_op(64'(lw), OCW);
        ln       = AW'(f_n(64'(lw), OCW, DDW));
        lcnt     = ((lop == OP_OUT || lop == OP_RET || lop == OP_STOP || lop == 3'd7) && ln != '0)
                   ? ln - 1'b1 : '0;
        do_load  = (adv && !halt || fifo_pop) && valid(la);
        go_idle  = adv && !do_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            pc     <= '0;
            data_o <= '0;
            cnt    <= '0;
            sp     <= '0;
        end else begin
            if (do_load) begin
                run    <= 1'b1;
                pc     <= la;
                data_o <= DDW'(f_d(64'(lw), DDW));
                cnt    <= lcnt;
            end else if (go_idle) begin
                run <= 1'b0;
                pc  <= '0;
            end else if (run) begin
                cnt <= cnt - 1'b1;
            end
            if (adv && push && sp != SPW'(STD)) sp <= sp + 1'b1;
            else if (adv && pop) sp <= sp - 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (adv && push && sp != SPW'(STD)) stk[SIW'(sp)] <= push_val;
        else if (adv && wtop) stk[SIW'(sp - 1'b1)] <= top - 1'b1;

endmodule

// File: tb/tb_seq_engine.sv
// tb_seq_engine: scoreboard bench for seq_engine; expected (pc, data_o) per running cycle
// are queued with each command and popped by a monitor whenever stop is low.
module tb_seq_engine;

    typedef struct packed {
        logic [4:0] pc;
        logic [3:0] d;
    } exp_t;

    function automatic logic [11:0] mk(input int op, input int n, input int d);
        return {3'(op), 5'(n), 4'(d)};
    endfunction

    function automatic logic [371:0] put(input logic [371:0] p, input int i, input logic [11:0] w);
        p[(30 - i)*12 +: 12] = w;
        return p;
    endfunction

    function automatic logic [371:0] build();
        logic [371:0] p;
        p = '0;
        p = put(p, 2,  mk(1, 2, 9));
        p = put(p, 3,  mk(1, 2, 12));
        p = put(p, 4,  mk(4, 2, 6));
        p = put(p, 5,  mk(1, 2, 3));
        p = put(p, 6,  mk(0, 18, 9));
        p = put(p, 19, mk(5, 3, 0));
        p = put(p, 20, mk(3, 3, 9));
        p = put(p, 21, mk(6, 20, 3));
        p = put(p, 22, mk(1, 2, 9));
        p = put(p, 23, mk(0, 24, 0));
        return p;
    endfunction

    localparam logic [371:0] PROG = build();

    logic       clk, rst_n, wr_en, fifo_full, fifo_empty, stop;
    logic [4:0] wr_addr, pc;
    logic [3:0] data_o;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   runs = 0;
    int   base, w_cnt;

    seq_engine #(.PROGRAM(PROG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .data_o     (data_o),
        .pc         (pc),
        .stop       (stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ex(input int p, input int d, input int k);
        exp_t e;
        e.pc = 5'(p);
        e.d  = 4'(d);
        repeat (k) q.push_back(e);
    endtask

    task automatic exp_prog3();
        ex(3, 12, 2); ex(4, 6, 2); ex(5, 3, 2); ex(6, 9, 18);
    endtask

    task automatic exp_prog2();
        ex(2, 9, 2);
        exp_prog3();
    endtask

    task automatic exp_prog19();
        ex(19, 0, 1);
        repeat (3) begin
            ex(20, 9, 1); ex(3, 12, 2); ex(4, 6, 2); ex(21, 3, 1);
        end
        ex(22, 9, 2); ex(23, 0, 24);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input int a);
        wr_addr = 5'(a);
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0 && stop && fifo_empty) break;
        end
        checks++;
        if (i == budget) begin
            errors++;
            $display("FAIL %s: no return to idle within %0d cycles, %0d expected outputs left",
                     name, budget, q.size());
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b1;
                continue;
            end
            if (!stop) begin
                if (prev) runs++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got pc=%0d data=%b, expected idle", pc, data_o);
                end else begin
                    e = q.pop_front();
                    if ({pc, data_o} !== e) begin
                        errors++;
                        $display("FAIL data_seq: got pc=%0d data=%b, expected pc=%0d data=%b",
                                 pc, data_o, e.pc, e.d);
                    end
                end
            end
            prev = stop;
        end
    endtask

    initial begin
        wr_en   = 1'b0;
        wr_addr = '0;
        rst_n   = 1'b1;
        fork monitor(); join_none
        #3 rst_n = 1'b0;
        #4;
        chk("reset_pc", pc, 0);
        chk("reset_stop", stop, 1);
        chk("reset_data", data_o, 0);
        chk("reset_fifo_empty", fifo_empty, 1);
        chk("reset_fifo_full", fifo_full, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run with an entry still queued
        exp_prog2();
        wr(2);
        wr(3);
        repeat (4) @(negedge clk);
        chk("midrun_running", stop, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_pc", pc, 0);
        chk("midrun_stop", stop, 1);
        chk("midrun_data", data_o, 0);
        chk("midrun_fifo_empty", fifo_empty, 1);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Program 2 with first-output latency
        exp_prog2();
        wr(2);
        chk("latency_pre", stop, 1);
        @(negedge clk);
        chk("latency_start", stop, 0);
        wait_idle(200, "prog2_idle");
        chk("prog2_end_pc", pc, 0);
        chk("prog2_end_stop", stop, 1);
        chk("prog2_end_data", data_o, 9);

        // Program 19: PUSHI, CALL/RET, counted loop
        exp_prog19();
        wr(19);
        wait_idle(300, "prog19_idle");
        chk("prog19_end_pc", pc, 0);
        chk("prog19_end_data", data_o, 0);

        // Back-to-back queue with an invalid entry in the middle
        base = runs;
        exp_prog2();
        exp_prog19();
        wr(2);
        wr(0);
        wr(19);
        wait_idle(400, "queue_idle");
        chk("queue_runs", runs - base, 2);

        // Fill the FIFO behind a running program, then try one extra write of entry 3
        base = runs;
        exp_prog2();
        wr_addr = 5'd2;
        wr_en   = 1'b1;
        @(negedge clk);
        w_cnt = 0;
        for (int i = 0; i < 700; i++) begin
            if (fifo_full && !stop) break;
            wr_addr = 5'd6;
            wr_en   = !fifo_full;
            if (!fifo_full) begin
                ex(6, 9, 18);
                w_cnt++;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("fill_full", fifo_full, 1);
        wr(3);
        chk("full_after_drop", fifo_full, 1);
        wait_idle(9000, "drain_idle");
        chk("fill_runs", runs - base, w_cnt + 1);
        chk("drain_empty", fifo_empty, 1);

        // Program 3: RET sees an empty stack
        exp_prog3();
        wr(3);
        wait_idle(200, "prog3_idle");
        chk("prog3_end_pc", pc, 0);
        chk("prog3_end_stop", stop, 1);
        chk("prog3_end_data", data_o, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_engine.md
Name: seq_engine

Overview:
- Microcoded output sequencer with an integrated command FIFO of entry addresses.
- A host queues program entry addresses. While idle, the engine pops the next address and executes the parameter-ROM program from that address until it reaches a STOP.
- Each instruction drives a DDW-bit pattern on data_o for one or more cycles.
- Supports CALL/RET and counted loops through an internal stack. Used as a waveform/pattern generator.

Parameters:
- OCW, 12, instruction width; format [opcode 3][n AW][d DDW]; AW = OCW-DDW-3 (5 by default).
- DDW, 4, output data width.
- PLEN, 31, number of program words; word 0 is reserved.
- STD, 256, stack depth in entries of AW bits.
- FDEPTH, 256, command FIFO depth in entries of AW bits.
- PROGRAM, all zero, PLEN*OCW bits; word i occupies bits [(PLEN-1-i)*OCW +: OCW], so word 0 is the MSBs.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, push wr_addr into the FIFO.
- wr_addr, in, AW, program entry address.
- fifo_full, out, 1, FIFO full.
- fifo_empty, out, 1, FIFO empty.
- data_o, out, DDW, current output pattern (registered).
- pc, out, AW, current program counter; 0 while idle.
- stop, out, 1, high while idle.

Behaviour:
- Reset (async): pc=0, stop=1, data_o=0, hold counter=0, stack empty, FIFO empty.
- Opcodes (3 bits): STOP=0, OUT=1, JMP=2, CALL=3, RET=4, PUSHI=5, DECJNZ=6. Code 7 is treated as STOP.
- Dwell n_eff = max(n,1) cycles for OUT/RET/STOP. All other opcodes dwell exactly 1 cycle.
- On the edge that loads instruction A: pc<=A, data_o<=d[A], counter<=n_eff-1. After the dwell the next edge loads the successor.
- OUT: successor pc+1.
- JMP: successor n.
- CALL: push pc+1; successor n.
- RET with stack non-empty: pop; successor is the popped value.
- RET with stack empty: behaves as OUT.
- PUSHI: push n; successor pc+1.
- DECJNZ: top-1 != 0 → write back top-1, successor n. Otherwise pop, successor pc+1. With stack empty it behaves as OUT with a 1-cycle dwell.
- STOP: after the dwell, go idle: stop<=1, pc<=0, data_o holds the STOP's d.
- A successor of 0 or >= PLEN goes idle instead of executing.
- Idle with FIFO non-empty: pop one entry at an edge.
  - Entry 0 or >= PLEN: discard it, stay idle.
  - Otherwise load that instruction at the same edge: stop<=0.
- Latency: write at edge k → first pattern on data_o after edge k+1, provided the engine is idle.
- Stack push when full is dropped. Pop when empty is a no-op.
- FIFO write when full is dropped, except when a pop occurs on the same edge, in which case the write is accepted.
- FIFO pop and write on the same edge while empty: the written entry is not popped until the next edge.
- Writes while running are queued. Each STOP returns to idle; the next entry starts the edge after stop rises.

Decomposition:
- Shared package seq_pkg holds the opcode constants, the field-slice helpers, and a program-word concatenation macro per opcode.
- One sub-module, seq_cmd_fifo: synchronous FIFO, AW wide, FDEPTH deep, async active-low reset, with full/empty flags.
- Stack, PC and decode stay in seq_engine.

Test Plan:
- Test program words:
  - 2: OUT n2 1001; 3: OUT n2 1100; 4: RET n2 0110; 5: OUT n2 0011; 6: STOP n18 1001.
  - 19: PUSHI 3; 20: CALL 3 1001; 21: DECJNZ 20 0011; 22: OUT n2 1001; 23: STOP n24 0000.
  - All other words STOP n0.
- Reset mid-run: assert rst_n low during execution → pc=0, stop=1, data_o=0 immediately; FIFO empty.
- Write 2 → stop falls; data_o sequence 1001×2, 1100×2, 0110×2 (empty-stack RET), 0011×2, 1001×18; then stop=1, pc=0.
- Write 19 → data_o sequence 0000×1, then [1001×1, 1100×2, 0110×2, 0011×1] ×3, then 1001×2, 0000×24; then stop=1. Stack empty at end.
- Queue 2, 0, 19 back to back → program 2 runs; entry 0 is discarded while idle, with stop staying 1 for that edge; program 19 then runs. Total of two runs.
- Fill the FIFO with FDEPTH writes → fifo_full=1; an extra write is dropped.
- Write 3 → data_o sequence 1100×2, 0110×2 (empty-stack RET), 0011×2, 1001×18; then idle.
